// File: rtl/video_source_switcher.sv
// video_source_switcher
//   Frame-aligned 2:1 selector between two Avalon-ST video sources feeding a
//   single VGA sink. The output changes owner only after an endofpacket
//   handshake, and the new owner is picked up only from its next
//   startofpacket, so the sink never sees a partial frame. Counts forwarded
//   frames and flags a source that takes too long to deliver startofpacket.
//
// Ports
//   clk, reset        system clock, synchronous active-low reset (0 = in reset)
//   sel               requested source, sampled only on an eop handshake
//   s0_* / s1_*       source 0 / source 1 stream (data, valid, sop, eop, ready)
//   m_*               stream to the VGA sink (data, valid, sop, eop, ready)
//   active_src        source currently owning the output
//   switch_pending    sel differs from active_src
//   frame_count       eop handshakes forwarded on m_*, wraps at 0xFFFF
//   sync_timeout      sticky: waited SYNC_TIMEOUT cycles for sop in SYNC
module video_source_switcher #(
  parameter int unsigned DATA_W       = 12,
  parameter bit          DEFAULT_SRC  = 1'b0,
  parameter int unsigned SYNC_TIMEOUT = 1_000_000,
  parameter bit          IDLE_DRAIN   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  input  logic              s0_sop,
  input  logic              s0_eop,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  input  logic              s1_sop,
  input  logic              s1_eop,
  output logic              s1_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_sop,
  output logic              m_eop,
  input  logic              m_ready,
  output logic              active_src,
  output logic              switch_pending,
  output logic [15:0]       frame_count,
  output logic              sync_timeout
);

  typedef enum logic {SYNC, STREAM} state_t;

  localparam int unsigned          CNT_W   = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     TO_MAX  = CNT_W'(SYNC_TIMEOUT);
  localparam logic [CNT_W-1:0]     TO_LAST = CNT_W'(SYNC_TIMEOUT - 1);

  state_t             state, state_nxt;
  logic               active_nxt;
  logic [CNT_W-1:0]   to_cnt;

  logic [DATA_W-1:0]  act_data;
  logic               act_valid, act_sop, act_eop, act_ready;
  logic               frame_done;

  // Selected-source view
  always_comb begin
    act_data  = active_src ? s1_data  : s0_data;
    act_valid = active_src ? s1_valid : s0_valid;
    act_sop   = active_src ? s1_sop   : s0_sop;
    act_eop   = active_src ? s1_eop   : s0_eop;
  end

  assign frame_done     = (state == STREAM) && act_valid && m_ready && act_eop;
  assign switch_pending = (sel != active_src);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= SYNC;
      active_src   <= DEFAULT_SRC;
      frame_count  <= '0;
      sync_timeout <= 1'b0;
      to_cnt       <= '0;
    end else begin
      state      <= state_nxt;
      active_src <= active_nxt;
      if (frame_done)
        frame_count <= frame_count + 16'd1;
      // Counter only runs while waiting for sop; any move to STREAM clears it.
      if (state == SYNC && state_nxt == SYNC) begin
        if (to_cnt < TO_MAX)
          to_cnt <= to_cnt + 1'b1;
        if (to_cnt >= TO_LAST)
          sync_timeout <= 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    active_nxt = active_src;
    case (state)
      SYNC: begin
        if (act_valid && act_sop)
          state_nxt = STREAM;
      end
      STREAM: begin
        if (frame_done && (sel != active_src)) begin
          state_nxt  = SYNC;
          active_nxt = sel;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Output logic: pure pass-through, everything gated off while in reset
  always_comb begin
    m_data    = act_data;
    m_valid   = 1'b0;
    m_sop     = 1'b0;
    m_eop     = 1'b0;
    act_ready = 1'b0;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    if (reset) begin
      case (state)
        // Discard beats until sop; hold the sop beat for STREAM to forward.
        SYNC:   act_ready = !(act_valid && act_sop);
        STREAM: begin
          m_valid   = act_valid;
          m_sop     = act_sop;
          m_eop     = act_eop;
          act_ready = m_ready;
        end
        default: act_ready = 1'b0;
      endcase
      s0_ready = active_src ? IDLE_DRAIN : act_ready;
      s1_ready = active_src ? act_ready  : IDLE_DRAIN;
    end
  end

endmodule

// File: tb/tb_video_source_switcher.sv
module tb_video_source_switcher;

  logic        clk = 1'b0;
  logic        reset, sel;
  logic [11:0] s0_data, s1_data, m_data;
  logic        s0_valid, s0_sop, s0_eop, s0_ready;
  logic        s1_valid, s1_sop, s1_eop, s1_ready;
  logic        m_valid, m_sop, m_eop, m_ready;
  logic        active_src, switch_pending, sync_timeout;
  logic [15:0] frame_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [13:0] sb[$];
  logic [13:0] exp_beat;

  always #5 clk = ~clk;

  video_source_switcher #(
    .DATA_W(12), .DEFAULT_SRC(1'b0), .SYNC_TIMEOUT(8), .IDLE_DRAIN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_sop(s0_sop), .s0_eop(s0_eop), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_sop(s1_sop), .s1_eop(s1_eop), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
    .active_src(active_src), .switch_pending(switch_pending),
    .frame_count(frame_count), .sync_timeout(sync_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every m_* handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      check("beat_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_beat = sb.pop_front();
        check("m_beat", {18'd0, m_data, m_sop, m_eop}, {18'd0, exp_beat});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit src, input bit v, input logic [11:0] d, input bit sop, input bit eop);
    if (src) begin
      s1_valid = v; s1_data = d; s1_sop = sop; s1_eop = eop;
    end else begin
      s0_valid = v; s0_data = d; s0_sop = sop; s0_eop = eop;
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the posedge that took the beat.
  task automatic send_beat(input bit src, input logic [11:0] d, input bit sop, input bit eop);
    int unsigned n;
    bit done;
    n = 0;
    done = 1'b0;
    drive(src, 1'b1, d, sop, eop);
    while (!done && n < 50) begin
      @(negedge clk);
      if ((src ? s1_ready : s0_ready) === 1'b1) done = 1'b1;
      else n++;
    end
    check("handshake_in_time", 32'(done), 1);
    step(1);
    drive(src, 1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [11:0] d, input bit sop, input bit eop);
    sb.push_back({d, sop, eop});
  endtask

  task automatic send_frame(input bit src, input logic [11:0] base);
    for (int unsigned i = 0; i < 4; i++) begin
      push(base + 12'(i), i == 0, i == 3);
      send_beat(src, base + 12'(i), i == 0, i == 3);
    end
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0; m_ready = 1'b1;
    drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_s0_ready", s0_ready, 0);
    check("rst_s1_ready", s1_ready, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_active_src", active_src, 0);
    check("rst_sync_timeout", sync_timeout, 0);
    check("rst_switch_pending", switch_pending, 0);
    step(1);
    reset = 1'b1;

    // Frame from src0: sop is held in SYNC, forwarded the following cycle
    for (int unsigned i = 0; i < 4; i++) push(12'hA00 + 12'(i), i == 0, i == 3);
    drive(1'b0, 1'b1, 12'hA00, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_sop_held_ready", s0_ready, 0);
    check("t1_sync_m_valid", m_valid, 0);
    step(1);
    check("t1_first_m_valid", m_valid, 1);
    check("t1_first_m_sop", m_sop, 1);
    check("t1_first_m_data", m_data, 12'hA00);
    send_beat(1'b0, 12'hA00, 1'b1, 1'b0);
    send_beat(1'b0, 12'hA01, 1'b0, 1'b0);
    send_beat(1'b0, 12'hA02, 1'b0, 1'b0);
    send_beat(1'b0, 12'hA03, 1'b0, 1'b1);
    check("t1_frame_count", frame_count, 1);
    check("t1_oth_drain", s1_ready, 1);

    // Back-pressure for 5 cycles mid-frame
    for (int unsigned i = 0; i < 4; i++) push(12'hC00 + 12'(i), i == 0, i == 3);
    send_beat(1'b0, 12'hC00, 1'b1, 1'b0);
    send_beat(1'b0, 12'hC01, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 12'hC02, 1'b0, 1'b0);
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_m_valid", m_valid, 1);
      check("t4_stall_m_data", m_data, 12'hC02);
      check("t4_stall_s0_ready", s0_ready, 0);
    end
    step(1);
    m_ready = 1'b1;
    send_beat(1'b0, 12'hC02, 1'b0, 1'b0);
    send_beat(1'b0, 12'hC03, 1'b0, 1'b1);
    check("t4_frame_count", frame_count, 2);

    // Switch request mid-frame takes effect only after the eop handshake
    for (int unsigned i = 0; i < 4; i++) push(12'hF00 + 12'(i), i == 0, i == 3);
    send_beat(1'b0, 12'hF00, 1'b1, 1'b0);
    sel = 1'b1;
    #1;
    check("t3_pending_set", switch_pending, 1);
    send_beat(1'b0, 12'hF01, 1'b0, 1'b0);
    send_beat(1'b0, 12'hF02, 1'b0, 1'b0);
    check("t3_active_before_eop", active_src, 0);
    check("t3_pending_before_eop", switch_pending, 1);
    send_beat(1'b0, 12'hF03, 1'b0, 1'b1);
    check("t3_active_after_eop", active_src, 1);
    check("t3_pending_after_eop", switch_pending, 0);
    check("t3_frame_count", frame_count, 3);
    // src1 non-sop beats are discarded while waiting for sop
    drive(1'b1, 1'b1, 12'hB02, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_discard_m_valid", m_valid, 0);
    check("t3_discard_s1_ready", s1_ready, 1);
    check("t3_oth_s0_ready", s0_ready, 1);
    step(1);
    drive(1'b1, 1'b1, 12'hB03, 1'b0, 1'b1);
    @(negedge clk);
    check("t3_discard_eop_m_valid", m_valid, 0);
    step(1);
    send_frame(1'b1, 12'h900);
    check("t3_src1_frame_count", frame_count, 4);

    // Reset mid-frame at pixel 2
    push(12'h700, 1'b1, 1'b0);
    push(12'h701, 1'b0, 1'b0);
    send_beat(1'b1, 12'h700, 1'b1, 1'b0);
    send_beat(1'b1, 12'h701, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 12'h702, 1'b0, 1'b0);
    reset = 1'b0;
    step(1);
    check("t6_m_valid", m_valid, 0);
    check("t6_frame_count", frame_count, 0);
    check("t6_active_src", active_src, 0);
    check("t6_switch_pending", switch_pending, 1);
    check("t6_s1_ready", s1_ready, 0);
    check("t6_s0_ready", s0_ready, 0);
    drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    sel = 1'b0;
    step(1);
    reset = 1'b1;

    // src0 joins mid-frame: trailing pixels are consumed, not forwarded
    drive(1'b0, 1'b1, 12'h502, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_p2_m_valid", m_valid, 0);
    check("t2_p2_s0_ready", s0_ready, 1);
    step(1);
    drive(1'b0, 1'b1, 12'h503, 1'b0, 1'b1);
    @(negedge clk);
    check("t2_p3_m_valid", m_valid, 0);
    check("t2_p3_s0_ready", s0_ready, 1);
    step(1);
    send_frame(1'b0, 12'h500);
    check("t2_frame_count", frame_count, 1);
    check("t2_sync_timeout", sync_timeout, 0);

    // Switch to src1 which never sends sop: timeout after 8 SYNC cycles
    for (int unsigned i = 0; i < 4; i++) push(12'h300 + 12'(i), i == 0, i == 3);
    send_beat(1'b0, 12'h300, 1'b1, 1'b0);
    sel = 1'b1;
    send_beat(1'b0, 12'h301, 1'b0, 1'b0);
    send_beat(1'b0, 12'h302, 1'b0, 1'b0);
    send_beat(1'b0, 12'h303, 1'b0, 1'b1);
    check("t5_active_src", active_src, 1);
    step(7);
    check("t5_timeout_cycle7", sync_timeout, 0);
    step(1);
    check("t5_timeout_cycle8", sync_timeout, 1);
    step(5);
    check("t5_timeout_sticky", sync_timeout, 1);
    send_frame(1'b1, 12'h400);
    check("t5_resume_frame_count", frame_count, 3);
    check("t5_timeout_after_stream", sync_timeout, 1);
    reset = 1'b0;
    step(2);
    check("t5_timeout_cleared", sync_timeout, 0);
    reset = 1'b1;
    step(1);

    check("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
